// File: rtl/coin_pulse_conditioner.sv
// Coin-sensor front end: 2-FF synchronizer, debounce/qualify FSM, post-release
// holdoff, jam detection and a saturating accepted-coin counter. Produces one
// registered single-cycle x pulse per physical coin for the vending FSM.
module coin_pulse_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLDOFF_CYCLES  = 8,
  parameter int JAM_CYCLES      = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       coin_raw,
  input  logic       enable,
  output logic       x,
  output logic       jam,
  output logic [7:0] coin_count
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > HOLDOFF_CYCLES) ? DEBOUNCE_CYCLES : HOLDOFF_CYCLES;
  localparam int MAX_P  = (MAX_AB > JAM_CYCLES) ? MAX_AB : JAM_CYCLES;
  localparam int CW     = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYCLES - 1);
  localparam logic [CW-1:0] JAM_LAST  = CW'(JAM_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUAL_HI,
    S_ACCEPT,
    S_WAIT_LOW,
    S_JAM,
    S_HOLDOFF
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;      // shared per-state counter, cleared on state change
  logic [CW-1:0] hi_cnt, hi_nxt;    // cycles elapsed since ACCEPT, drives jam detection
  logic          sync1, s;

  // Two-flop synchronizer for the asynchronous sensor line.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every flop samples
      // the pre-edge value; blocking here would collapse the two stages into one.
      sync1 <= coin_raw;
      s     <= sync1;
    end
  end

  // State and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      hi_cnt <= '0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      hi_cnt <= hi_nxt;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    state_nxt = state;
    cnt_nxt   = cnt;
    hi_nxt    = hi_cnt;
    case (state)
      S_IDLE: begin
        if (s && enable) begin
          state_nxt = S_QUAL_HI;
          cnt_nxt   = CNT_ONE;
        end
      end
      S_QUAL_HI: begin
        if (!s || !enable) begin
          state_nxt = S_IDLE;        // glitch or gated: drop without a pulse
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = S_ACCEPT;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ACCEPT: begin
        state_nxt = S_WAIT_LOW;
        cnt_nxt   = '0;
        hi_nxt    = CNT_ONE;         // the ACCEPT cycle counts toward the jam time
      end
      S_WAIT_LOW: begin
        // A completed release wins over a jam declared on the same edge.
        // The jam timer measures total time since ACCEPT, so a sensor that
        // keeps chattering without a clean release is also treated as jammed.
        if (!s && (cnt == DEB_LAST)) begin
          state_nxt = S_HOLDOFF;
          cnt_nxt   = '0;
        end else if (hi_cnt == JAM_LAST) begin
          state_nxt = S_JAM;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = s ? '0 : cnt + 1'b1;
          hi_nxt  = hi_cnt + 1'b1;
        end
      end
      S_JAM: begin
        if (s) begin
          cnt_nxt = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = S_HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLDOFF: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x          <= 1'b0;
      jam        <= 1'b0;
      coin_count <= 8'd0;
    end else begin
      x   <= (state_nxt == S_ACCEPT);
      jam <= (state_nxt == S_JAM);
      if ((state_nxt == S_ACCEPT) && (coin_count != 8'hFF)) begin
        coin_count <= coin_count + 8'd1;
      end
    end
  end

endmodule
